cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Run controller that sequences the single-cycle CPU for bring-up and regression.
- Streams a program into instruction memory while the CPU is held in reset, then releases reset and lets the CPU run.
- Stops the run on a halt instruction or a cycle limit, then freezes the CPU and latches the CPU result and cycle count.
- Sits between the test/host side and the cpu top: it owns the CPU reset and the imem write port.

Parameters:
- ADDR_W, 8, imem word-address width; depth = 2**ADDR_W words.
- CNT_W, 16, width of the cycle counter and of cycle_limit.
- RST_CYCLES, 2, cycles cpu_rst is held high before a run (must be >=1).
- HALT_INSN, 32'h0000_0073, instruction encoding that ends a run (ecall).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  program word available.
- load_data  in  32  program word.
- load_last  in  1  marks the final word of the program.
- load_ready  out  1  controller accepts a word.
- start  in  1  single-cycle run request.
- cycle_limit  in  CNT_W  maximum run cycles; 0 = unlimited; sampled on start.
- imem_we  out  1  imem write enable.
- imem_waddr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_rst  out  1  reset to the CPU.
- cpu_instr  in  32  instruction currently executing.
- cpu_result  in  32  CPU result bus.
- busy  out  1  high in LOAD, RST_CPU, RUN.
- done  out  1  run finished.
- timeout  out  1  run ended by cycle_limit.
- load_ovf  out  1  program exceeded imem depth.
- run_cycles  out  CNT_W  RUN-state cycle count of the last run.
- final_result  out  32  cpu_result captured at the end of the run.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE and the loaded flag clears.
  - cpu_rst=1; busy, done, timeout, load_ovf = 0.
  - run_cycles=0, final_result=0, write pointer=0.
  - rst overrides everything, including mid-LOAD and mid-RUN; no further imem writes occur.
- The handshake accepts a word when load_valid & load_ready.
  - imem_we = accept, combinational in the same cycle.
  - imem_waddr = write pointer; imem_wdata = load_data.
- FSM states: IDLE, LOAD, RST_CPU, RUN, DONE.
- IDLE:
  - cpu_rst=1, load_ready=1.
  - An accepted word writes address 0, clears load_ovf and done, and sets pointer=1.
    - If load_last, set loaded and stay IDLE; otherwise go to LOAD.
  - start with loaded=1 goes to RST_CPU and samples cycle_limit.
  - start with loaded=0 is ignored.
  - If start and a load beat occur in the same cycle, the load wins and start is ignored.
- LOAD:
  - cpu_rst=1, load_ready=1, start ignored.
  - Each accepted word writes at the pointer, then the pointer increments.
  - An accepted word with load_last sets loaded and goes to IDLE.
  - An accepted word at address 2**ADDR_W-1 without load_last:
    - sets load_ovf and loaded, and goes to IDLE;
    - no wrap-around overwrite occurs;
    - later words are treated as a new program starting at address 0.
- RST_CPU:
  - cpu_rst=1, load_ready=0.
  - Stays exactly RST_CYCLES cycles, then goes to RUN.
  - Clears the counter, done and timeout.
- RUN:
  - cpu_rst=0, load_ready=0; counter increments every cycle.
  - Let n = counter+1 for the current cycle. Checks in priority order:
    1. cpu_instr==HALT_INSN → DONE, timeout=0.
    2. cycle_limit!=0 and n==cycle_limit → DONE, timeout=1.
  - On either exit, run_cycles<=n and final_result<=cpu_result in the same edge.
  - With cycle_limit=0 the counter saturates at all-ones and never times out.
  - start and load_valid are ignored in RUN.
- DONE:
  - cpu_rst=1 (CPU frozen), done=1, load_ready=1.
  - start → RST_CPU to rerun the same program; done clears on entry to RST_CPU.
  - An accepted load beat behaves as in IDLE: clears done and loaded, then writes address 0.
- Outputs run_cycles, final_result, timeout and load_ovf hold their values until the next run or load that updates them.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum run_state_t {IDLE, LOAD, RST_CPU, RUN, DONE};
  - HALT_ECALL constant;
  - default CNT_W.
- The FSM and counter live in this module.
- One natural sub-module: imem_loader, covering the pointer, handshake, overflow detect and load-done pulse.

Test Plan:
- Load 3 words (0x00500093, 0x00108113, 0x00000073), last on the 3rd:
  - writes occur at addresses 0,1,2 on 3 consecutive cycles;
  - state returns to IDLE with loaded=1.
- start, cycle_limit=0; bench drives cpu_instr=HALT_INSN on the 4th RUN cycle with cpu_result=0x6:
  - cpu_rst high for exactly 2 cycles, then low;
  - done=1, run_cycles=4, final_result=0x6, timeout=0, cpu_rst back to 1.
- cycle_limit=10, no halt: DONE after 10 RUN cycles with timeout=1 and run_cycles=10.
- Halt coincides with the limit (cycle_limit=4, halt on cycle 4): timeout=0, run_cycles=4.
- ADDR_W=2, 5 words with last on the 5th:
  - 4 writes at addresses 0..3, then load_ovf=1;
  - the 5th word writes address 0 of a new load.
- Reset and ignored-start cases:
  - start with no program loaded → stays IDLE, cpu_rst=1;
  - rst asserted mid-RUN → next cycle IDLE, cpu_rst=1, done=0, loaded=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared types and constants for the CPU run controller.
//             Holds the run-state encoding, the halt instruction encoding
//             and the default cycle-counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int          CNT_W_DEFAULT = 16;
    localparam logic [31:0] HALT_ECALL    = 32'h0000_0073;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RST_CPU = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Program-streaming front end for the instruction memory.
//             Owns the write pointer, the valid/ready handshake, overflow
//             detection and the end-of-program indication.
//  Ports    : clk, rst         - clock / synchronous active-high reset
//             enable           - controller is able to take program words
//             in_program       - continue the current program at the pointer;
//                                when low an accepted word starts a new
//                                program at address 0
//             load_valid/data/last, load_ready - host handshake
//             imem_we/waddr/wdata              - imem write port
//             accept           - a word is taken this cycle
//             load_end         - accepted word closes the program
//             load_ovf         - sticky: last program ran past the top
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_program,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              accept,
    output logic              load_end,
    output logic              load_ovf
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_ovf;
    logic [ADDR_W-1:0] w_addr;
    logic              w_at_top;
    logic              w_ovf;

    // A word arriving outside LOAD always begins a fresh program at 0.
    assign w_addr   = in_program ? r_ptr : '0;
    assign w_at_top = &w_addr;

    assign load_ready = enable;
    assign accept     = load_valid & enable;
    assign imem_we    = accept;
    assign imem_waddr = w_addr;
    assign imem_wdata = load_data;

    // Filling the top word without seeing load_last closes the program
    // instead of wrapping over address 0.
    assign w_ovf    = accept & ~load_last & w_at_top;
    assign load_end = accept & (load_last | w_at_top);
    assign load_ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else if (accept) begin
            // Wraps to 0 after the top word; harmless because the next
            // program restarts at 0 regardless of the pointer.
            r_ptr <= w_addr + ADDR_W'(1);
            if (w_ovf)
                r_ovf <= 1'b1;
            else if (!in_program)
                r_ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Purpose  : Bring-up / regression run controller for the single-cycle CPU.
//             Streams a program into imem with the CPU held in reset, then
//             pulses the CPU reset, runs until a halt instruction or a cycle
//             limit, freezes the CPU and latches the result and cycle count.
//  Ports    : clk, rst                        - clock / sync active-high reset
//             load_valid/data/last, load_ready - program stream from host
//             start, cycle_limit               - run request (limit 0 = none)
//             imem_we/waddr/wdata              - imem write port
//             cpu_rst, cpu_instr, cpu_result   - CPU control and observation
//             busy, done, timeout, load_ovf    - status
//             run_cycles, final_result         - results of the last run
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int          CNT_W      = CNT_W_DEFAULT,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] HALT_INSN  = HALT_ECALL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic [CNT_W-1:0]  cycle_limit,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    input  logic [31:0]       cpu_instr,
    input  logic [31:0]       cpu_result,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_ovf,
    output logic [CNT_W-1:0]  run_cycles,
    output logic [31:0]       final_result
);

    localparam int                c_RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RC_W-1:0] c_RST_LAST = c_RC_W'(RST_CYCLES - 1);

    run_state_t        r_state;
    run_state_t        w_state_nxt;
    logic              r_loaded;
    logic [c_RC_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_limit;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_run_cycles;
    logic [31:0]       r_final_result;

    logic              w_enable;
    logic              w_in_program;
    logic              w_accept;
    logic              w_load_end;
    logic              w_start_run;
    logic              w_run_exit;
    logic              w_halt;
    logic [CNT_W-1:0]  w_n;

    // Decoded straight from the state register so the loader handshake
    // never depends on the next-state logic that consumes it.
    assign w_enable     = (r_state == IDLE) || (r_state == LOAD) || (r_state == DONE);
    assign w_in_program = (r_state == LOAD);

    imem_loader #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .enable     (w_enable),
        .in_program (w_in_program),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .accept     (w_accept),
        .load_end   (w_load_end),
        .load_ovf   (load_ovf)
    );

    // Cycle number of the current RUN cycle; sticks at all-ones so an
    // unlimited run cannot wrap.
    assign w_n = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_run_exit  = 1'b0;
        w_halt      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                // A load beat takes precedence over a same-cycle start.
                if (w_load_end)
                    w_state_nxt = IDLE;
                else if (w_accept)
                    w_state_nxt = LOAD;
                else if (start && r_loaded) begin
                    w_state_nxt = RST_CPU;
                    w_start_run = 1'b1;
                end
            end
            LOAD: begin
                if (w_load_end)
                    w_state_nxt = IDLE;
            end
            RST_CPU: begin
                if (r_rst_cnt == c_RST_LAST)
                    w_state_nxt = RUN;
            end
            RUN: begin
                if (cpu_instr == HALT_INSN) begin
                    w_state_nxt = DONE;
                    w_run_exit  = 1'b1;
                    w_halt      = 1'b1;
                end else if ((r_limit != '0) && (w_n == r_limit)) begin
                    w_state_nxt = DONE;
                    w_run_exit  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loaded       <= 1'b0;
            r_rst_cnt      <= '0;
            r_cnt          <= '0;
            r_limit        <= '0;
            r_timeout      <= 1'b0;
            r_run_cycles   <= '0;
            r_final_result <= '0;
        end else begin
            // Any accepted word reopens the program; only its closing word
            // marks it runnable again.
            if (w_accept)
                r_loaded <= w_load_end;

            if (w_start_run) begin
                r_limit   <= cycle_limit;
                r_cnt     <= '0;
                r_timeout <= 1'b0;
                r_rst_cnt <= '0;
            end

            if (r_state == RST_CPU)
                r_rst_cnt <= r_rst_cnt + c_RC_W'(1);

            if (r_state == RUN) begin
                r_cnt <= w_n;
                if (w_run_exit) begin
                    r_run_cycles   <= w_n;
                    r_final_result <= cpu_result;
                    r_timeout      <= ~w_halt;
                end
            end
        end
    end

    assign cpu_rst      = (r_state != RUN);
    assign busy         = (r_state == LOAD) || (r_state == RST_CPU) || (r_state == RUN);
    assign done         = (r_state == DONE);
    assign timeout      = r_timeout;
    assign run_cycles   = r_run_cycles;
    assign final_result = r_final_result;

endmodule
`default_nettype wire
